// File: rtl/data_memory_if.sv
// CPU memory port, loader word stream and output byte stream of data_memory.
interface data_memory_if;
  logic [7:0]  mem_addr;
  logic [15:0] mem_in;
  logic        mem_we;
  logic [15:0] mem_out;
  logic        cpu_hold;
  logic        load_valid;
  logic [15:0] load_data;
  logic        load_last;
  logic        load_ready;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_ready;

  modport slave (
    input  mem_addr, mem_in, mem_we, load_valid, load_data, load_last, out_ready,
    output mem_out, cpu_hold, load_ready, out_valid, out_data
  );

  modport master (
    output mem_addr, mem_in, mem_we, load_valid, load_data, load_last, out_ready,
    input  mem_out, cpu_hold, load_ready, out_valid, out_data
  );
endinterface

// File: rtl/data_memory.sv
// Word-organised CPU data memory with a post-reset stream loader.
// Define DATA_MEMORY_MMIO_EN to map word 127 onto an output byte FIFO.
module data_memory #(
  parameter int unsigned DEPTH_WORDS = 128,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  data_memory_if.slave bus_io
);

  localparam int unsigned AW = 7;
  localparam logic [AW-1:0] LAST_WORD = AW'(DEPTH_WORDS - 1);
  localparam logic [0:0] ST_LOAD = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]    state_q, state_d;
  logic [AW-1:0] load_ptr_q, load_ptr_d;
  logic [15:0]   mem_q [DEPTH_WORDS];

  logic [AW-1:0] cpu_word_c;
  logic          mmio_sel_c;
  logic [15:0]   status_c;
  logic          ram_we_c;
  logic [AW-1:0] ram_waddr_c;
  logic [15:0]   ram_wdata_c;

  assign cpu_word_c = bus_io.mem_addr[7:1];

  // Loader/run state and load pointer
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_LOAD;
      load_ptr_q <= '0;
    end else begin
      state_q    <= state_d;
      load_ptr_q <= load_ptr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    load_ptr_d = load_ptr_q;
    if (state_q == ST_LOAD && bus_io.load_valid) begin
      load_ptr_d = load_ptr_q + AW'(1);
      if (bus_io.load_last || load_ptr_q == LAST_WORD) state_d = ST_RUN;
    end
  end

  assign bus_io.cpu_hold   = (state_q == ST_LOAD);
  assign bus_io.load_ready = (state_q == ST_LOAD);

  // Single RAM write port shared by the loader and the CPU
  always_comb begin
    ram_we_c    = 1'b0;
    ram_waddr_c = cpu_word_c;
    ram_wdata_c = bus_io.mem_in;
    if (state_q == ST_LOAD) begin
      ram_we_c    = bus_io.load_valid;
      ram_waddr_c = load_ptr_q;
      ram_wdata_c = bus_io.load_data;
    end else begin
      ram_we_c = bus_io.mem_we && !mmio_sel_c;
    end
  end

  always_ff @(posedge clk_i) begin
    if (ram_we_c && !rst_i) mem_q[ram_waddr_c] <= ram_wdata_c;
  end

  always_comb begin
    bus_io.mem_out = 16'h0000;
    if (state_q == ST_RUN) bus_io.mem_out = mmio_sel_c ? status_c : mem_q[cpu_word_c];
  end

`ifdef DATA_MEMORY_MMIO_EN
  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [7:0]    fifo_q [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;
  logic          push_c, pop_c, full_c, push_ok_c;

  assign mmio_sel_c = (cpu_word_c == LAST_WORD);

  // A push at full is accepted only when the head leaves in the same cycle
  always_comb begin
    pop_c     = (count_q != '0) && bus_io.out_ready;
    full_c    = (count_q == CW'(FIFO_DEPTH));
    push_c    = (state_q == ST_RUN) && bus_io.mem_we && mmio_sel_c;
    push_ok_c = push_c && (!full_c || pop_c);
    rd_ptr_d  = rd_ptr_q + PW'(pop_c);
    wr_ptr_d  = wr_ptr_q + PW'(push_ok_c);
    count_d   = count_q + CW'(push_ok_c) - CW'(pop_c);
    ovf_d     = ovf_q || (push_c && !push_ok_c);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok_c && !rst_i) fifo_q[wr_ptr_q] <= bus_io.mem_in[7:0];
  end

  assign status_c         = {ovf_q, 4'b0000, 3'(count_q), 8'h00};
  assign bus_io.out_valid = (count_q != '0);
  assign bus_io.out_data  = (count_q != '0) ? fifo_q[rd_ptr_q] : 8'h00;

  logic unused_ok_c;
  assign unused_ok_c = bus_io.mem_addr[0];
`else
  localparam int unsigned fifo_depth_unused = FIFO_DEPTH;

  assign mmio_sel_c       = 1'b0;
  assign status_c         = 16'h0000;
  assign bus_io.out_valid = 1'b0;
  assign bus_io.out_data  = 8'h00;

  logic unused_ok_c;
  assign unused_ok_c = ^{bus_io.mem_addr[0], bus_io.out_ready};
`endif

endmodule
